// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: vector/response bus between the sweeper,
// the two candidate implementations and the golden ROM.
interface truth_table_sweeper_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 5
);
  logic [IN_W-1:0]  o_x;
  logic [IN_W-1:0]  o_rom_addr;
  logic [OUT_W-1:0] i_y_a;
  logic [OUT_W-1:0] i_y_b;
  logic [OUT_W-1:0] i_rom_data;

  modport master (
    output o_x,
    output o_rom_addr,
    input  i_y_a,
    input  i_y_b,
    input  i_rom_data
  );

  modport slave (
    input  o_x,
    input  o_rom_addr,
    output i_y_a,
    output i_y_b,
    output i_rom_data
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive A/B-vs-golden-ROM sweep checker.
// Optional first-failure capture: TRUTH_SWEEP_FIRST_FAIL_EN.
module truth_table_sweeper_dly #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] p_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) p_q[i] <= '0;
    end else begin
      p_q[0] <= d_i;
      for (int i = 1; i < N; i++) p_q[i] <= p_q[i-1];
    end
  end

  assign q_o = p_q[N-1];
endmodule

module truth_table_sweeper #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 5,
  parameter int DUT_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  truth_table_sweeper_if.master bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [IN_W:0]        o_err_cnt,
  output logic [1:0]           o_err_mask
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
  ,
  output logic                 o_fail_vld,
  output logic [IN_W-1:0]      o_fail_x,
  output logic [OUT_W-1:0]     o_fail_a,
  output logic [OUT_W-1:0]     o_fail_b,
  output logic [OUT_W-1:0]     o_fail_gold
`endif
);
  localparam int D  = (DUT_LAT > 1) ? DUT_LAT : 1;
  localparam int GD = D - 1;
  localparam int YD = D - DUT_LAT;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {
    IDLE, SWEEP, DRAIN, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] x_q, x_d;
  logic [CW-1:0]   drn_q, drn_d;
  logic [IN_W:0]   cnt_q, cnt_d;
  logic [1:0]      mask_q, mask_d;

  logic [OUT_W-1:0] gold_al, ya_al, yb_al;
  logic             tag_al;
  logic             mism_a, mism_b, hit, go;

  // Bring golden word, DUT outputs and the valid tag to a common cycle
  if (GD == 0) begin : g_gold_w
    assign gold_al = bus.i_rom_data;
  end else begin : g_gold_d
    truth_table_sweeper_dly #(.W(OUT_W), .N(GD)) u_dly (
      .clk, .rst, .d_i(bus.i_rom_data), .q_o(gold_al)
    );
  end

  if (YD == 0) begin : g_y_w
    assign {yb_al, ya_al} = {bus.i_y_b, bus.i_y_a};
  end else begin : g_y_d
    truth_table_sweeper_dly #(.W(2*OUT_W), .N(YD)) u_dly (
      .clk, .rst,
      .d_i({bus.i_y_b, bus.i_y_a}),
      .q_o({yb_al, ya_al})
    );
  end

  truth_table_sweeper_dly #(.W(1), .N(D)) u_tag (
    .clk, .rst, .d_i(state_q == SWEEP), .q_o(tag_al)
  );

  assign mism_a = (ya_al != gold_al);
  assign mism_b = (yb_al != gold_al);
  assign hit    = tag_al & (mism_a | mism_b);
  assign go     = i_start & ((state_q == IDLE) | (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      drn_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    drn_d   = drn_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (hit) cnt_d = cnt_q + (IN_W+1)'(1);
    if (tag_al) mask_d = mask_q | {mism_b, mism_a};
    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = SWEEP;
          x_d     = '0;
          cnt_d   = '0;
          mask_d  = '0;
        end
      end
      SWEEP: begin
        if (x_q == '1) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          x_d = x_q + IN_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == CW'(D - 1)) state_d = DONE;
        else drn_d = drn_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_x        = x_q;
  assign bus.o_rom_addr = x_q;
  assign o_busy         = (state_q == SWEEP) | (state_q == DRAIN);
  assign o_done         = (state_q == DONE);
  assign o_pass         = o_done & (cnt_q == '0);
  assign o_err_cnt      = cnt_q;
  assign o_err_mask     = mask_q;

`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
  logic [IN_W-1:0]  x_al;
  logic             fvld_q;
  logic [IN_W-1:0]  fx_q;
  logic [OUT_W-1:0] fa_q, fb_q, fg_q;

  truth_table_sweeper_dly #(.W(IN_W), .N(D)) u_xdly (
    .clk, .rst, .d_i(x_q), .q_o(x_al)
  );

  always_ff @(posedge clk) begin
    if (rst || go) begin
      fvld_q <= 1'b0;
      fx_q   <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      fg_q   <= '0;
    end else if (hit && !fvld_q) begin
      fvld_q <= 1'b1;
      fx_q   <= x_al;
      fa_q   <= ya_al;
      fb_q   <= yb_al;
      fg_q   <= gold_al;
    end
  end

  assign o_fail_vld  = fvld_q;
  assign o_fail_x    = fx_q;
  assign o_fail_a    = fa_q;
  assign o_fail_b    = fb_q;
  assign o_fail_gold = fg_q;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: sweeps a 37-nonzero table through
// combinational (LAT0) and 3-stage piped (LAT3/LAT2) candidates.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  bit   a_fault, b_stuck;
  logic [4:0] rom [256];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cnt;
    logic [1:0] mask;
    bit         pass;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  truth_table_sweeper_if #(.IN_W(8), .OUT_W(5)) if0 ();
  truth_table_sweeper_if #(.IN_W(8), .OUT_W(5)) if3 ();
  truth_table_sweeper_if #(.IN_W(8), .OUT_W(5)) if2 ();

  logic busy0, done0, pass0, busy3, done3, pass3;
  logic busy2, done2, pass2;
  logic [8:0] cnt0, cnt3, cnt2;
  logic [1:0] mask0, mask3, mask2;
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
  logic fv0, fv3, fv2;
  logic [7:0] fx0, fx3, fx2;
  logic [4:0] fa0, fb0, fg0, fa3, fb3, fg3, fa2, fb2, fg2;
`endif

  truth_table_sweeper #(.IN_W(8), .OUT_W(5), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .i_start(start), .bus(if0.master),
    .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_cnt(cnt0), .o_err_mask(mask0)
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    , .o_fail_vld(fv0), .o_fail_x(fx0), .o_fail_a(fa0),
    .o_fail_b(fb0), .o_fail_gold(fg0)
`endif
  );

  truth_table_sweeper #(.IN_W(8), .OUT_W(5), .DUT_LAT(3)) u3 (
    .clk(clk), .rst(rst), .i_start(start), .bus(if3.master),
    .o_busy(busy3), .o_done(done3), .o_pass(pass3),
    .o_err_cnt(cnt3), .o_err_mask(mask3)
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    , .o_fail_vld(fv3), .o_fail_x(fx3), .o_fail_a(fa3),
    .o_fail_b(fb3), .o_fail_gold(fg3)
`endif
  );

  truth_table_sweeper #(.IN_W(8), .OUT_W(5), .DUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .i_start(start), .bus(if2.master),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_cnt(cnt2), .o_err_mask(mask2)
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    , .o_fail_vld(fv2), .o_fail_x(fx2), .o_fail_a(fa2),
    .o_fail_b(fb2), .o_fail_gold(fg2)
`endif
  );

  always @(posedge clk) begin
    if0.i_rom_data <= rom[if0.o_rom_addr];
    if3.i_rom_data <= rom[if3.o_rom_addr];
    if2.i_rom_data <= rom[if2.o_rom_addr];
  end

  always_comb begin
    if0.i_y_a = rom[if0.o_x] ^
      ((a_fault && if0.o_x == 8'h3C) ? 5'd1 : 5'd0);
    if0.i_y_b = b_stuck ? 5'd0 : rom[if0.o_x];
  end

  // Correct table behind three register stages for both LAT3 and LAT2
  logic [4:0] p3 [3];
  logic [4:0] p2 [3];
  always @(posedge clk) begin
    p3[0] <= rom[if3.o_x];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    p2[0] <= rom[if2.o_x];
    p2[1] <= p2[0];
    p2[2] <= p2[1];
  end
  assign if3.i_y_a = p3[2];
  assign if3.i_y_b = p3[2];
  assign if2.i_y_a = p2[2];
  assign if2.i_y_b = p2[2];

  function automatic logic [4:0] ya_of(input int v);
    return rom[v] ^ ((a_fault && v == 'h3C) ? 5'd1 : 5'd0);
  endfunction

  function automatic logic [4:0] yb_of(input int v);
    return b_stuck ? 5'd0 : rom[v];
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.cnt = 0;
    e.mask = 2'b00;
    for (int v = 0; v < 256; v++) begin
      if (ya_of(v) != rom[v] || yb_of(v) != rom[v]) e.cnt++;
      if (ya_of(v) != rom[v]) e.mask[0] = 1'b1;
      if (yb_of(v) != rom[v]) e.mask[1] = 1'b1;
    end
    e.pass = (e.cnt == 0);
    e.cyc = 258;
    return e;
  endfunction

  task automatic run_sweep(input int pulse_at, input int rst_at,
                           input int hold);
    exp_t e;
    int c, c0, c3, c2, run_cnt, v;
    e = model();
    if (rst_at == 0) sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    c = 1;
    if (hold <= 1) start = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0 || if0.o_x !== 8'h00) begin
      errors++;
      $display("FAIL start_cycle1: busy=%b done=%b x=%h need 1 0 00",
               busy0, done0, if0.o_x);
    end
    run_cnt = 0; c0 = 0; c3 = 0; c2 = 0;
    while (c < 400) begin
      v = c - 3;
      if (v >= 0 && v < 256)
        if (ya_of(v) != rom[v] || yb_of(v) != rom[v]) run_cnt++;
      checks++;
      if (cnt0 !== 9'(run_cnt)) begin
        errors++;
        $display("FAIL running_cnt c=%0d: got %0d need %0d",
                 c, cnt0, run_cnt);
      end
      if (done0 && c0 == 0) c0 = c;
      if (done3 && c3 == 0) c3 = c;
      if (done2 && c2 == 0) c2 = c;
      if (c0 != 0 && c3 != 0 && c2 != 0) break;
      if (c == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (if0.o_x !== 8'h00 || if0.o_rom_addr !== 8'h00 ||
            busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 ||
            cnt0 !== 9'd0 || mask0 !== 2'b00 || busy3 !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid: x=%h a=%h b=%b d=%b p=%b c=%0d m=%b need 0",
                   if0.o_x, if0.o_rom_addr, busy0, done0, pass0,
                   cnt0, mask0);
        end
        return;
      end
      if (c == pulse_at) start = 1'b1;
      else if (c >= hold) start = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (c0 != e.cyc) begin
      errors++;
      $display("FAIL done_cycle0: got %0d need %0d", c0, e.cyc);
    end
    checks++;
    if (cnt0 !== 9'(e.cnt) || mask0 !== e.mask || pass0 !== e.pass) begin
      errors++;
      $display("FAIL result0: cnt=%0d mask=%b pass=%b need %0d %b %b",
               cnt0, mask0, pass0, e.cnt, e.mask, e.pass);
    end
    checks++;
    if (busy0 !== 1'b0 || if0.o_x !== 8'hFF || if0.o_rom_addr !== 8'hFF) begin
      errors++;
      $display("FAIL done_state0: busy=%b x=%h addr=%h need 0 ff ff",
               busy0, if0.o_x, if0.o_rom_addr);
    end
    checks++;
    if (c3 != 260 || pass3 !== 1'b1 || cnt3 !== 9'd0) begin
      errors++;
      $display("FAIL lat3: cyc=%0d pass=%b cnt=%0d need 260 1 0",
               c3, pass3, cnt3);
    end
    checks++;
    if (c2 != 259 || cnt2 == 9'd0 || pass2 !== 1'b0) begin
      errors++;
      $display("FAIL lat2_misaligned: cyc=%0d cnt=%0d pass=%b need 259 >0 0",
               c2, cnt2, pass2);
    end
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    checks++;
    if (fv0 !== (e.cnt != 0)) begin
      errors++;
      $display("FAIL fail_vld: got %b need %b", fv0, e.cnt != 0);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (if0.o_x !== 8'h00 || if0.o_rom_addr !== 8'h00 ||
        busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 ||
        cnt0 !== 9'd0 || mask0 !== 2'b00) begin
      errors++;
      $display("FAIL reset: x=%h b=%b d=%b p=%b c=%0d m=%b need all 0",
               if0.o_x, busy0, done0, pass0, cnt0, mask0);
    end
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    checks++;
    if (fv0 !== 1'b0 || fx0 !== 8'h00 || fg0 !== 5'd0) begin
      errors++;
      $display("FAIL reset_fail: vld=%b x=%h g=%h need 0", fv0, fx0, fg0);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_sweep();
    a_fault = 1'b0;
    b_stuck = 1'b0;
    run_sweep(0, 0, 1);
  endtask

  task automatic test_a_fault();
    a_fault = 1'b1;
    b_stuck = 1'b0;
    run_sweep(0, 0, 1);
`ifdef TRUTH_SWEEP_FIRST_FAIL_EN
    checks++;
    if (fx0 !== 8'h3C || fg0 !== rom['h3C] ||
        fa0 !== (rom['h3C] ^ 5'd1) || fb0 !== rom['h3C]) begin
      errors++;
      $display("FAIL first_fail: x=%h a=%h b=%h g=%h need 3c %h %h %h",
               fx0, fa0, fb0, fg0, rom['h3C] ^ 5'd1, rom['h3C],
               rom['h3C]);
    end
`endif
    a_fault = 1'b0;
  endtask

  task automatic test_b_stuck();
    b_stuck = 1'b1;
    run_sweep(0, 0, 1);
    b_stuck = 1'b0;
  endtask

  task automatic test_start_ignored();
    run_sweep(50, 0, 1);
  endtask

  task automatic test_reset_mid();
    run_sweep(0, 100, 1);
    run_sweep(0, 0, 1);
  endtask

  task automatic test_back_to_back();
    b_stuck = 1'b1;
    run_sweep(0, 0, 1);
    b_stuck = 1'b0;
    run_sweep(0, 0, 3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = (i % 7 == 0) ? 5'(((i * 3) % 31) + 1) : 5'd0;
    a_fault = 1'b0;
    b_stuck = 1'b0;
    test_reset();
    test_clean_sweep();
    test_a_fault();
    test_b_stuck();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: got %0d need 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
